nfc_op_arbiter: RTL



---
 rtl/nfc_op_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/nfc_op_arbiter.sv
// Round-robin arbiter/sequencer sharing one NAND flash controller start/done port
// among NREQ requesters, with a done watchdog and per-requester completion pulses.
module nfc_op_arbiter #(
   parameter int NREQ      = 4,
   parameter int CMD_WIDTH = 3,
   parameter int ROW_W     = 16,
   parameter int TIMEOUT   = 65535
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NREQ-1:0]           req_i,
   input  logic [NREQ*CMD_WIDTH-1:0] req_cmd_i,
   input  logic [NREQ*ROW_W-1:0]     req_addr_i,
   output logic [NREQ-1:0]           gnt_o,
   output logic [NREQ-1:0]           done_o,
   output logic [2:0]                err_o,
   output logic                      timeout_o,
   output logic                      busy_o,
   output logic                      nfc_strt_o,
   output logic [CMD_WIDTH-1:0]      nfc_cmd_o,
   output logic [ROW_W-1:0]          page_address_o,
   input  logic                      nfc_done_i,
   input  logic                      perr_i,
   input  logic                      eerr_i,
   input  logic                      rerr_i
);

   localparam int PTR_W = $clog2(NREQ);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_RELEASE
   } state_t;

   state_t               state_reg;
   logic [PTR_W-1:0]     ptr_reg;
   logic [PTR_W-1:0]     win_reg;
   logic [PTR_W-1:0]     win_next;
   logic [CNT_W-1:0]     cnt_reg;
   logic [NREQ-1:0]      gnt_reg;
   logic [NREQ-1:0]      done_reg;
   logic [2:0]           err_reg;
   logic                 timeout_reg;
   logic                 strt_reg;
   logic [CMD_WIDTH-1:0] cmd_reg;
   logic [ROW_W-1:0]     addr_reg;
   logic                 any_req;
   logic [PTR_W:0]       sum;

   logic [CMD_WIDTH-1:0] cmd_arr  [NREQ];
   logic [ROW_W-1:0]     addr_arr [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign cmd_arr[gi]  = req_cmd_i[gi*CMD_WIDTH +: CMD_WIDTH];
         assign addr_arr[gi] = req_addr_i[gi*ROW_W +: ROW_W];
      end
   endgenerate

   // Walk offsets from high to low so the requester nearest ptr wins last.
   always_comb begin
      any_req  = |req_i;
      win_next = ptr_reg;
      sum      = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         sum = {1'b0, ptr_reg} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(NREQ))
            sum = sum - (PTR_W+1)'(NREQ);
         if (req_i[sum[PTR_W-1:0]])
            win_next = sum[PTR_W-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg   <= ST_IDLE;
         ptr_reg     <= '0;
         win_reg     <= '0;
         cnt_reg     <= '0;
         gnt_reg     <= '0;
         done_reg    <= '0;
         err_reg     <= '0;
         timeout_reg <= 1'b0;
         strt_reg    <= 1'b0;
         cmd_reg     <= '1;
         addr_reg    <= '0;
      end else begin
         strt_reg    <= 1'b0;
         done_reg    <= '0;
         timeout_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (any_req) begin
                  win_reg   <= win_next;
                  gnt_reg   <= NREQ'(1) << win_next;
                  cmd_reg   <= cmd_arr[win_next];
                  addr_reg  <= addr_arr[win_next];
                  strt_reg  <= 1'b1;
                  state_reg <= ST_START;
               end
            end
            ST_START: begin
               cnt_reg   <= '0;
               state_reg <= ST_WAIT;
            end
            ST_WAIT: begin
               // A done on the last watchdog count still counts as a normal completion.
               if (nfc_done_i) begin
                  err_reg   <= {perr_i, eerr_i, rerr_i};
                  done_reg  <= gnt_reg;
                  state_reg <= ST_RELEASE;
               end else if (cnt_reg == CNT_LAST) begin
                  err_reg     <= '0;
                  done_reg    <= gnt_reg;
                  timeout_reg <= 1'b1;
                  state_reg   <= ST_RELEASE;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            ST_RELEASE: begin
               gnt_reg   <= '0;
               ptr_reg   <= (win_reg == PTR_W'(NREQ - 1)) ? '0 : win_reg + PTR_W'(1);
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign gnt_o          = gnt_reg;
   assign done_o         = done_reg;
   assign err_o          = err_reg;
   assign timeout_o      = timeout_reg;
   assign busy_o         = (state_reg != ST_IDLE);
   assign nfc_strt_o     = strt_reg;
   assign nfc_cmd_o      = cmd_reg;
   assign page_address_o = addr_reg;

endmodule
